tt_um_alexlowl_my_tt_project: RTL and testbench

- Tiny Tapeout user tile implementing a start/stop stopwatch counter with a programmable prescaler and a hex 7-segment readout.
- A rising edge on ui_in[0] toggles run/stop.
- An 8-bit counter advances on prescaler ticks while running.
- The low or high nibble of the count drives the 7-segment output; the full count drives the bidirectional pins.

---
 rtl/tt_um_alexlowl_my_tt_project.sv | 110 +++++++++++
 tb/tb_tt_um_alexlowl_my_tt_project.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_alexlowl_my_tt_project.sv
// Stopwatch tile: a start/stop button toggles run, a 16-bit prescaler divides
// the clock by 2^SEL, and an 8-bit up/down counter advances on each
// prescaler tick. One nibble of the count is shown on a hex 7-segment
// display, and the full count is driven on the bidirectional pins.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   ena     tile enable (ignored)
//   ui_in   [0] start/stop, [1] clear, [2] dir (1=down), [3] nibble sel,
//           [7:4] prescaler select SEL
//   uo_out  [6:0] segments a..g (active-high), [7] run flag
//   uio_in  unused
//   uio_out current count
//   uio_oe  all ones (bidirectional pins are always outputs)
module tt_um_alexlowl_my_tt_project (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // The name keeps lint quiet about the tile inputs this design ignores.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in};

  // Start button: two synchronizer stages plus one delay stage for edge detect.
  logic [2:0]  start_pipe;
  logic [1:0]  clr_pipe;
  logic        run;
  logic [15:0] presc;
  logic [7:0]  count;

  logic        rise;
  logic        clear;
  logic        tick;
  logic [15:0] limit;
  logic [3:0]  nib;
  logic [6:0]  seg;

  assign rise  = start_pipe[1] & ~start_pipe[2];
  assign clear = clr_pipe[1];
  // 2^SEL - 1; SEL is used unsynchronized because it is quasi-static.
  assign limit = (16'd1 << ui_in[7:4]) - 16'd1;
  assign tick  = run && (presc == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pipe <= '0;
      clr_pipe   <= '0;
    end else begin
      start_pipe <= {start_pipe[1:0], ui_in[0]};
      clr_pipe   <= {clr_pipe[0], ui_in[1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else if (rise) run <= ~run;
  end

  // If SEL drops below the current prescaler value, presc runs on to 0xFFFF
  // and wraps to 0; that wrap produces no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else if (clear || tick) presc <= '0;
    else if (run) presc <= presc + 16'd1;
  end

  // Clear has priority over tick. Arithmetic wraps modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (tick) count <= ui_in[2] ? count - 8'd1 : count + 8'd1;
  end

  assign nib = ui_in[3] ? count[7:4] : count[3:0];

  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign uo_out  = {run, seg};
  assign uio_out = count;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_alexlowl_my_tt_project.sv
module tb_tt_um_alexlowl_my_tt_project;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  tt_um_alexlowl_my_tt_project dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then sample 1ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset state
    step(5);
    chk("rst_uo", uo_out, 8'h3F);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_uo", uo_out, 8'h3F);
    chk("post_rst_uio", uio_out, 8'h00);

    // Start, SEL=0, up. Input first seen at edge k, run toggles at k+2.
    ui_in = 8'h01;
    step(3);                          // after k+2
    chk("start_run", uo_out, 8'hBF);
    chk("start_cnt", uio_out, 8'h00);
    step(2);                          // after k+4: ticks at k+3,k+4
    chk("run_cnt2", uio_out, 8'h02);
    ui_in = 8'h00;
    step(5);                          // after k+9
    ui_in = 8'h01;                    // seen at k+10 -> stop at k+12
    step(3);
    chk("stop_cnt", uio_out, 8'h0A);
    chk("stop_uo", uo_out, 8'h77);
    ui_in = 8'h00;
    step(100);
    chk("frozen_cnt", uio_out, 8'h0A);
    chk("frozen_uo", uo_out, 8'h77);

    // Clear while stopped, then SEL=3 for 80 running edges.
    ui_in = 8'h32;
    step(3);
    ui_in = 8'h30;
    step(2);
    chk("clr_stopped", uio_out, 8'h00);
    chk("clr_run_kept", uo_out, 8'h3F);
    ui_in = 8'h31;
    step(5);
    ui_in = 8'h30;
    step(75);
    ui_in = 8'h31;
    step(3);
    chk("sel3_cnt", uio_out, 8'h0A);
    chk("sel3_stopped", uo_out, 8'h77);

    // SEL=4 for 160 running edges.
    ui_in = 8'h42;
    step(3);
    ui_in = 8'h40;
    step(2);
    chk("clr2", uio_out, 8'h00);
    ui_in = 8'h41;
    step(5);
    ui_in = 8'h40;
    step(155);
    ui_in = 8'h41;
    step(3);
    chk("sel4_cnt", uio_out, 8'h0A);
    ui_in = 8'h40;

    // Down wrap from 0, SEL=0.
    ui_in = 8'h02;
    step(3);
    ui_in = 8'h00;
    step(2);
    chk("clr3", uio_out, 8'h00);
    ui_in = 8'h05;
    step(3);                          // after k+2: run on
    chk("down_start", uio_out, 8'h00);
    step(1);                          // after k+3: one down tick
    chk("down_wrap", uio_out, 8'hFF);
    chk("down_lo_nib", uo_out, 8'hF1);
    ui_in = 8'h0D;
    #1;
    chk("down_hi_nib", uo_out, 8'hF1);
    ui_in = 8'h01;                    // back to up, low nibble
    step(1);                          // after k+4
    chk("up_wrap", uio_out, 8'h00);
    chk("up_wrap_uo", uo_out, 8'hBF);
    ui_in = 8'h00;
    step(53);                         // after k+57
    chk("cnt35", uio_out, 8'h35);

    // Clear while running: seen at k+58, applied from k+60.
    ui_in = 8'h02;
    step(3);
    chk("clr_run_cnt", uio_out, 8'h00);
    chk("clr_run_flag", uo_out, 8'hBF);
    ui_in = 8'h00;
    step(2);                          // after k+62: clear still in pipe
    chk("clr_held", uio_out, 8'h00);
    step(1);
    chk("resume1", uio_out, 8'h01);
    step(4);
    chk("resume5", uio_out, 8'h05);

    // Async reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", uio_out, 8'h00);
    chk("arst_uo", uo_out, 8'h3F);
    chk("arst_oe", uio_oe, 8'hFF);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("arst_after", uo_out, 8'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
